ciphertext_ring_pointer: RTL and testbench
==========================================

Name: ciphertext_ring_pointer

Overview:
Parametrised read/write pointer controller for the ciphertext buffer RAM. The AES core writes finished blocks and the output interface drains them. The block tracks both pointers with wrap at an arbitrary DEPTH, which need not be a power of two. It keeps an occupancy count, produces empty/full/almost-full flags and sticky overflow/underflow error flags, and has a synchronous clear. It sits between the AES round controller (write side) and the ciphertext output stage (read side), driving the RAM address inputs directly.

Parameters:
ADDR_W, 9, pointer width in bits.
DEPTH, 512, number of buffer entries; 2 <= DEPTH <= 2**ADDR_W. Pointers wrap DEPTH-1 -> 0.
AFULL_LVL, 508, almost_full asserts when count >= AFULL_LVL; 1 <= AFULL_LVL <= DEPTH.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
clr  in  1  synchronous clear of pointers, count and flags; highest priority after rst
wr_en  in  1  write request (one entry)
rd_en  in  1  read request (one entry)
err_clr  in  1  synchronous clear of sticky error flags only
wr_ptr  out  ADDR_W  current write address
rd_ptr  out  ADDR_W  current read address
count  out  ADDR_W+1  entries held, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AFULL_LVL
wr_wrap  out  1  one-cycle pulse when wr_ptr wraps DEPTH-1 -> 0
overflow_err  out  1  sticky: write attempted while full and not simultaneously read
underflow_err  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=1, async): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, wr_wrap=0, overflow_err=0, underflow_err=0.
- All outputs are registered. An accepted request updates the pointers, count and flags on the next rising edge. Latency is 1 cycle.
- Acceptance, evaluated on current-cycle state:
  - rd_acc = rd_en & !empty.
  - wr_acc = wr_en & (!full | rd_en).
  - When full, a simultaneous write and read are both accepted; count is unchanged.
  - When empty, a simultaneous write and read accept the write only; the read is rejected and underflow_err is set.
- Pointer advance:
  - ptr_next = (ptr == DEPTH-1) ? 0 : ptr+1.
  - No other ptr values are reachable. DEPTH not a power of two must work.
- count_next = count + wr_acc - rd_acc, computed at ADDR_W+1 bits. It never exceeds DEPTH and never goes below 0.
- Flags are computed from count_next and registered, so they are always consistent with count.
- wr_wrap = 1 for exactly the cycle after an accepted write that took wr_ptr from DEPTH-1 to 0. Otherwise 0.
- Errors:
  - overflow_err sets when wr_en & full & !rd_en.
  - underflow_err sets when rd_en & empty.
  - Each holds until err_clr, clr or rst.
  - If a set condition and err_clr occur in the same cycle, set wins.
- clr: the next edge gives the same values as reset. Requests in the clr cycle are ignored, and no error flags are set in that cycle.
- Rejected requests change no pointer or count.
- Asserting rst mid-operation returns all state to reset values immediately. On rst release, operation resumes from 0 on the first edge with rst low.

Decomposition:
- Package ciphertext_ptr_pkg: default ADDR_W/DEPTH/AFULL_LVL constants, and a function ptr_inc(ptr, depth) implementing the wrap rule.
- Sub-module wrap_counter:
  - Parameters ADDR_W, DEPTH.
  - Ports clk, rst, clr, inc → ptr, wrap_pulse.
  - Instantiated twice, for the write and read sides.
- Top holds the acceptance logic, count, flags and error registers.

Test Plan:
- Reset, then DEPTH=6, AFULL_LVL=5: 6 consecutive writes → wr_ptr 1,2,3,4,5,0. wr_wrap pulses on the 6th edge. almost_full=1 at count=5, full=1 at count=6, empty=0 throughout.
- Full (count=6), wr_en alone → count stays 6, wr_ptr unchanged, overflow_err=1 and stays set. err_clr → overflow_err=0 next edge.
- Full, wr_en&rd_en together → both pointers advance, count=6, full stays 1, no error.
- Empty, rd_en&wr_en together → wr_ptr=1, rd_ptr=0, count=1, underflow_err=1.
- Count=3 with ptrs wr=4/rd=1, assert clr together with wr_en → all ptrs/count 0, empty=1, no errors. Repeat using async rst mid-cycle → outputs at 0 before the next clock edge.
- Default params: 1000 random wr/rd cycles against a reference model → ptr, count and flags match every cycle, and count never exceeds 512.

Source files
------------

// File: rtl/ciphertext_ptr_pkg.sv
// Shared constants and helpers for the ciphertext ring pointer block.
//   DEF_ADDR_W / DEF_DEPTH / DEF_AFULL_LVL : default geometry of the buffer
//   ptr_inc(ptr, depth)                    : next pointer value with wrap at depth-1
package ciphertext_ptr_pkg;

  localparam int DEF_ADDR_W    = 9;
  localparam int DEF_DEPTH     = 512;
  localparam int DEF_AFULL_LVL = 508;

  // Wrap is an explicit compare, not a modulo, so any depth works
  // (power of two or not) and only 0..depth-1 is ever produced.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/ciphertext_ring_pointer_wrap_counter.sv
// wrap_counter: one ring pointer that advances on inc and wraps DEPTH-1 -> 0.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   clr        : synchronous clear, overrides inc
//   inc        : advance the pointer by one entry
//   ptr        : registered pointer, 0..DEPTH-1
//   wrap_pulse : registered one-cycle pulse after an advance from DEPTH-1 to 0
module wrap_counter
  import ciphertext_ptr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic              wrap_pulse
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] ptr_reg;
  logic [ADDR_W-1:0] ptr_next;
  logic              wrap_reg;
  logic              wrap_next;

  always_comb begin
    ptr_next  = ptr_reg;
    wrap_next = 1'b0;
    if (clr) begin
      ptr_next = '0;
    end else if (inc) begin
      ptr_next  = ADDR_W'(ptr_inc(32'(ptr_reg), DEPTH));
      wrap_next = (ptr_reg == LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg  <= '0;
      wrap_reg <= 1'b0;
    end else begin
      ptr_reg  <= ptr_next;
      wrap_reg <= wrap_next;
    end
  end

  assign ptr        = ptr_reg;
  assign wrap_pulse = wrap_reg;

endmodule

// File: rtl/ciphertext_ring_pointer.sv
// ciphertext_ring_pointer: read/write pointer controller for the ciphertext
// buffer RAM, with occupancy count, level flags and sticky error flags.
//   clk, rst        : clock, asynchronous active-high reset
//   clr             : synchronous clear of pointers, count and all flags
//   wr_en / rd_en   : one-entry write / read requests
//   err_clr         : synchronous clear of the sticky error flags only
//   wr_ptr / rd_ptr : RAM addresses, 0..DEPTH-1
//   count           : entries held, 0..DEPTH
//   empty / full / almost_full : level flags, consistent with count
//   wr_wrap         : one-cycle pulse after wr_ptr wraps to 0
//   overflow_err / underflow_err : sticky request-error flags
module ciphertext_ring_pointer
  import ciphertext_ptr_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_LVL = DEF_AFULL_LVL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              wr_wrap,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam int CW = ADDR_W + 1;

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          empty_reg,  empty_next;
  logic          full_reg,   full_next;
  logic          afull_reg,  afull_next;
  logic          ovf_reg,    ovf_next;
  logic          unf_reg,    unf_next;

  logic          wr_acc;
  logic          rd_acc;
  logic          ovf_set;
  logic          unf_set;
  logic          rd_wrap_unused;

  // Acceptance uses the registered flags. When full, a paired read frees the
  // slot being written, so both are taken. When empty, a paired read has
  // nothing to return and is refused even though the write lands.
  assign rd_acc  = rd_en & ~empty_reg;
  assign wr_acc  = wr_en & (~full_reg | rd_en);
  assign ovf_set = wr_en & full_reg & ~rd_en;
  assign unf_set = rd_en & empty_reg;

  wrap_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_wr_ctr (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .inc        (wr_acc),
    .ptr        (wr_ptr),
    .wrap_pulse (wr_wrap)
  );

  wrap_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_rd_ctr (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .inc        (rd_acc),
    .ptr        (rd_ptr),
    .wrap_pulse (rd_wrap_unused)
  );

  always_comb begin
    count_next = count_reg + CW'(wr_acc) - CW'(rd_acc);
    // Error set takes priority over err_clr in the same cycle.
    ovf_next   = ovf_set | (ovf_reg & ~err_clr);
    unf_next   = unf_set | (unf_reg & ~err_clr);
    if (clr) begin
      count_next = '0;
      ovf_next   = 1'b0;
      unf_next   = 1'b0;
    end
    // Flags come from the next count so they register in step with it.
    empty_next = (count_next == '0);
    full_next  = (count_next == CW'(DEPTH));
    afull_next = (count_next >= CW'(AFULL_LVL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
      afull_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      empty_reg <= empty_next;
      full_reg  <= full_next;
      afull_reg <= afull_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  assign count         = count_reg;
  assign empty         = empty_reg;
  assign full          = full_reg;
  assign almost_full   = afull_reg;
  assign overflow_err  = ovf_reg;
  assign underflow_err = unf_reg;

endmodule

// File: tb/tb_ciphertext_ring_pointer.sv
module tb_ciphertext_ring_pointer;

  logic clk = 1'b0;
  logic rst;

  // Small instance: DEPTH=6 (not a power of two), AFULL_LVL=5.
  logic       s_wr, s_rd, s_clr, s_ec;
  logic [2:0] s_wr_ptr, s_rd_ptr;
  logic [3:0] s_count;
  logic       s_empty, s_full, s_afull, s_wrap, s_ovf, s_unf;

  // Default instance: ADDR_W=9, DEPTH=512, AFULL_LVL=508.
  logic       d_wr, d_rd, d_clr, d_ec;
  logic [8:0] d_wr_ptr, d_rd_ptr;
  logic [9:0] d_count;
  logic       d_empty, d_full, d_afull, d_wrap, d_ovf, d_unf;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ciphertext_ring_pointer #(.ADDR_W(3), .DEPTH(6), .AFULL_LVL(5)) dut_s (
    .clk(clk), .rst(rst), .clr(s_clr), .wr_en(s_wr), .rd_en(s_rd), .err_clr(s_ec),
    .wr_ptr(s_wr_ptr), .rd_ptr(s_rd_ptr), .count(s_count), .empty(s_empty),
    .full(s_full), .almost_full(s_afull), .wr_wrap(s_wrap),
    .overflow_err(s_ovf), .underflow_err(s_unf)
  );

  ciphertext_ring_pointer dut_d (
    .clk(clk), .rst(rst), .clr(d_clr), .wr_en(d_wr), .rd_en(d_rd), .err_clr(d_ec),
    .wr_ptr(d_wr_ptr), .rd_ptr(d_rd_ptr), .count(d_count), .empty(d_empty),
    .full(d_full), .almost_full(d_afull), .wr_wrap(d_wrap),
    .overflow_err(d_ovf), .underflow_err(d_unf)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int wp;
    int rp;
    int cnt;
    bit wrap;
    bit ovf;
    bit unf;
  } mdl_t;

  mdl_t ms, md;

  function automatic mdl_t step(input mdl_t m, input int depth,
                                input bit wr, input bit rd, input bit cl, input bit ec);
    mdl_t n;
    bit   wacc, racc;
    n = m;
    n.wrap = 1'b0;
    if (cl) begin
      n = '{default: 0};
      return n;
    end
    racc = rd && (m.cnt > 0);
    wacc = wr && ((m.cnt < depth) || rd);
    if (wr && (m.cnt == depth) && !rd) n.ovf = 1'b1;
    else if (ec)                        n.ovf = 1'b0;
    if (rd && (m.cnt == 0))             n.unf = 1'b1;
    else if (ec)                        n.unf = 1'b0;
    if (wacc) begin
      n.wp   = (m.wp + 1) % depth;
      n.wrap = (n.wp == 0);
    end
    if (racc) n.rp = (m.rp + 1) % depth;
    n.cnt = m.cnt + int'(wacc) - int'(racc);
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ms <= '{default: 0};
      md <= '{default: 0};
    end else begin
      ms <= step(ms, 6,   s_wr, s_rd, s_clr, s_ec);
      md <= step(md, 512, d_wr, d_rd, d_clr, d_ec);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("s_wr_ptr", int'(s_wr_ptr), ms.wp);
    check("s_rd_ptr", int'(s_rd_ptr), ms.rp);
    check("s_count",  int'(s_count),  ms.cnt);
    check("s_empty",  int'(s_empty),  int'(ms.cnt == 0));
    check("s_full",   int'(s_full),   int'(ms.cnt == 6));
    check("s_afull",  int'(s_afull),  int'(ms.cnt >= 5));
    check("s_wrap",   int'(s_wrap),   int'(ms.wrap));
    check("s_ovf",    int'(s_ovf),    int'(ms.ovf));
    check("s_unf",    int'(s_unf),    int'(ms.unf));
    check("d_wr_ptr", int'(d_wr_ptr), md.wp);
    check("d_rd_ptr", int'(d_rd_ptr), md.rp);
    check("d_count",  int'(d_count),  md.cnt);
    check("d_count_bound", int'(d_count <= 10'd512), 1);
    check("d_empty",  int'(d_empty),  int'(md.cnt == 0));
    check("d_full",   int'(d_full),   int'(md.cnt == 512));
    check("d_afull",  int'(d_afull),  int'(md.cnt >= 508));
    check("d_wrap",   int'(d_wrap),   int'(md.wrap));
    check("d_ovf",    int'(d_ovf),    int'(md.ovf));
    check("d_unf",    int'(d_unf),    int'(md.unf));
  end

  // ---------------- directed stimulus on the small instance ----------------
  int op_no = 0;

  task automatic lit(input int wp, input int rp, input int cnt, input bit emp,
                     input bit fl, input bit af, input bit wrp, input bit ovf, input bit unf);
    check("lit_wr_ptr", int'(s_wr_ptr), wp);
    check("lit_rd_ptr", int'(s_rd_ptr), rp);
    check("lit_count",  int'(s_count),  cnt);
    check("lit_empty",  int'(s_empty),  int'(emp));
    check("lit_full",   int'(s_full),   int'(fl));
    check("lit_afull",  int'(s_afull),  int'(af));
    check("lit_wrap",   int'(s_wrap),   int'(wrp));
    check("lit_ovf",    int'(s_ovf),    int'(ovf));
    check("lit_unf",    int'(s_unf),    int'(unf));
  endtask

  task automatic s_op(input bit wr, input bit rd, input bit cl, input bit ec,
                      input int wp, input int rp, input int cnt, input bit emp,
                      input bit fl, input bit af, input bit wrp, input bit ovf, input bit unf);
    s_wr = wr; s_rd = rd; s_clr = cl; s_ec = ec;
    @(posedge clk);
    #1;
    s_wr = 0; s_rd = 0; s_clr = 0; s_ec = 0;
    op_no++;
    $display("op %0d wr=%0d rd=%0d clr=%0d ec=%0d -> wr_ptr=%0d rd_ptr=%0d count=%0d ovf=%0d unf=%0d",
             op_no, wr, rd, cl, ec, s_wr_ptr, s_rd_ptr, s_count, s_ovf, s_unf);
    lit(wp, rp, cnt, emp, fl, af, wrp, ovf, unf);
  endtask

  initial begin
    rst = 1'b1;
    s_wr = 0; s_rd = 0; s_clr = 0; s_ec = 0;
    d_wr = 0; d_rd = 0; d_clr = 0; d_ec = 0;
    repeat (3) @(posedge clk);
    #1;
    lit(0, 0, 0, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Fill to full, wrap on the 6th write.
    for (int k = 1; k <= 5; k++)
      s_op(1, 0, 0, 0, k, 0, k, 0, 0, (k >= 5), 0, 0, 0);
    s_op(1, 0, 0, 0, 0, 0, 6, 0, 1, 1, 1, 0, 0);
    check("mdl_cnt_full", ms.cnt, 6);
    check("mdl_wp_wrapped", ms.wp, 0);
    // Overflow, stickiness, err_clr, set-wins-over-clear.
    s_op(1, 0, 0, 0, 0, 0, 6, 0, 1, 1, 0, 1, 0);
    s_op(0, 0, 0, 0, 0, 0, 6, 0, 1, 1, 0, 1, 0);
    s_op(0, 0, 0, 1, 0, 0, 6, 0, 1, 1, 0, 0, 0);
    s_op(1, 0, 0, 1, 0, 0, 6, 0, 1, 1, 0, 1, 0);
    s_op(0, 0, 0, 1, 0, 0, 6, 0, 1, 1, 0, 0, 0);
    // Full with simultaneous write and read.
    s_op(1, 1, 0, 0, 1, 1, 6, 0, 1, 1, 0, 0, 0);
    // Drain: rd_ptr 2,3,4,5,0,1.
    for (int k = 1; k <= 6; k++)
      s_op(0, 1, 0, 0, 1, (1 + k) % 6, 6 - k, (k == 6), 0, (6 - k >= 5), 0, 0, 0);
    // Read while empty.
    s_op(0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1);
    // clr returns everything to zero and clears errors.
    s_op(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Empty with write and read: write only, underflow set.
    s_op(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    s_op(1, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0, 1);
    s_op(1, 0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 1);
    s_op(1, 0, 0, 0, 4, 0, 4, 0, 0, 0, 0, 0, 1);
    s_op(0, 1, 0, 0, 4, 1, 3, 0, 0, 0, 0, 0, 1);
    // clr together with a write: write ignored.
    s_op(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    s_op(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    s_op(1, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    $display("async rst mid-cycle -> wr_ptr=%0d count=%0d empty=%0d", s_wr_ptr, s_count, s_empty);
    lit(0, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    s_op(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);

    // ---------------- random phase on both instances ----------------
    @(posedge clk);
    #1;
    for (int i = 0; i < 1000; i++) begin
      s_wr  = $urandom_range(0, 1) == 1;
      s_rd  = $urandom_range(0, 1) == 1;
      s_clr = $urandom_range(0, 99) == 0;
      s_ec  = $urandom_range(0, 19) == 0;
      if (i < 700) begin
        d_wr = 1'b1;
        d_rd = $urandom_range(0, 9) == 0;
      end else begin
        d_wr = $urandom_range(0, 9) == 0;
        d_rd = 1'b1;
      end
      d_ec = $urandom_range(0, 39) == 0;
      @(posedge clk);
      #1;
    end
    s_wr = 0; s_rd = 0; s_clr = 0; s_ec = 0;
    d_wr = 0; d_rd = 0; d_ec = 0;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
